// File: rtl/rect_loop_pkg.sv
// Shared types for the rectangle loop scheduler: FSM state enum,
// rectangle corner bundle and small helpers.
package rect_loop_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // Corners are held at a fixed 8-bit width; the top trims to IDX_W.
    typedef struct packed {
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] c1;
        logic [7:0] c2;
    } rect_idx_t;

    localparam rect_idx_t RECT_FIRST = '{r1: 8'd0, r2: 8'd1, c1: 8'd0, c2: 8'd1};

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rect_index_gen.sv
// Next-rectangle generator: steps (r1,r2,c1,c2) with r1<r2, c1<c2,
// c2 innermost, and flags the final rectangle of a matrix.
module rect_index_gen
    import rect_loop_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  rect_idx_t cur_i,
    output rect_idx_t nxt_o,
    output logic      last_rect_o
);

    always_comb begin
        nxt_o       = cur_i;
        last_rect_o = 1'b0;
        if (cur_i.c2 != 8'(COLS - 1)) begin
            nxt_o.c2 = cur_i.c2 + 8'd1;
        end else if (cur_i.c1 != 8'(COLS - 2)) begin
            nxt_o.c1 = cur_i.c1 + 8'd1;
            nxt_o.c2 = cur_i.c1 + 8'd2;
        end else if (cur_i.r2 != 8'(ROWS - 1)) begin
            nxt_o.r2 = cur_i.r2 + 8'd1;
            nxt_o.c1 = 8'd0;
            nxt_o.c2 = 8'd1;
        end else if (cur_i.r1 != 8'(ROWS - 2)) begin
            nxt_o.r1 = cur_i.r1 + 8'd1;
            nxt_o.r2 = cur_i.r1 + 8'd2;
            nxt_o.c1 = 8'd0;
            nxt_o.c2 = 8'd1;
        end else begin
            nxt_o       = RECT_FIRST;
            last_rect_o = 1'b1;
        end
    end

endmodule

// File: rtl/rect_loop_scheduler.sv
// Sweeps every rectangle of num_mats matrices through a flip controller.
// Define RECT_TIMEOUT_EN to bound the wait for fc_done.
module rect_loop_scheduler
    import rect_loop_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int IDX_W          = 2,
    parameter int MAT_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       base_addr,
    input  logic [7:0]       num_mats,
    output logic             fc_start,
    output logic [7:0]       fc_base_addr,
    output logic [IDX_W-1:0] fc_r1,
    output logic [IDX_W-1:0] fc_r2,
    output logic [IDX_W-1:0] fc_c1,
    output logic [IDX_W-1:0] fc_c2,
    input  logic             fc_done,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             timeout_err,
    output logic [15:0]      flip_count
);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] num_q, num_d;
    logic [7:0] mat_q, mat_d;
    rect_idx_t  idx_q, idx_d, idx_nxt;
    logic       last_rect;
    logic [15:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       abt_q, abt_d;
`ifdef RECT_TIMEOUT_EN
    logic [15:0] wait_q, wait_d;
    logic        terr_q, terr_d;
`endif

    rect_index_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_idx (
        .cur_i       (idx_q),
        .nxt_o       (idx_nxt),
        .last_rect_o (last_rect)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        num_d   = num_q;
        mat_d   = mat_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        abt_d   = abt_q;
`ifdef RECT_TIMEOUT_EN
        wait_d  = wait_q;
        terr_d  = terr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    num_d   = num_mats;
                    mat_d   = 8'd0;
                    idx_d   = RECT_FIRST;
                    cnt_d   = 16'd0;
                    pend_d  = 1'b0;
                    abt_d   = 1'b0;
`ifdef RECT_TIMEOUT_EN
                    terr_d  = 1'b0;
`endif
                    state_d = (num_mats == 8'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) pend_d = 1'b1;
`ifdef RECT_TIMEOUT_EN
                wait_d = 16'd0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) pend_d = 1'b1;
                if (fc_done) begin
                    cnt_d   = sat_inc16(cnt_q);
                    state_d = S_ADVANCE;
                end
`ifdef RECT_TIMEOUT_EN
                else if (wait_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
`endif
            end
            S_ADVANCE: begin
                // A pending abort wins even over normal completion.
                if (pend_q) begin
                    abt_d   = 1'b1;
                    state_d = S_DONE;
                end else if (last_rect && (mat_q == num_q - 8'd1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_nxt;
                    state_d = S_ISSUE;
                    if (last_rect) begin
                        mat_d  = mat_q + 8'd1;
                        addr_d = addr_q + 8'(MAT_BYTES);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 8'd0;
            num_q   <= 8'd0;
            mat_q   <= 8'd0;
            idx_q   <= '0;
            cnt_q   <= 16'd0;
            pend_q  <= 1'b0;
            abt_q   <= 1'b0;
`ifdef RECT_TIMEOUT_EN
            wait_q  <= 16'd0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            mat_q   <= mat_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            abt_q   <= abt_d;
`ifdef RECT_TIMEOUT_EN
            wait_q  <= wait_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign fc_start     = (state_q == S_ISSUE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign fc_base_addr = addr_q;
    assign fc_r1        = idx_q.r1[IDX_W-1:0];
    assign fc_r2        = idx_q.r2[IDX_W-1:0];
    assign fc_c1        = idx_q.c1[IDX_W-1:0];
    assign fc_c2        = idx_q.c2[IDX_W-1:0];
    assign flip_count   = cnt_q;
    assign aborted      = abt_q;
`ifdef RECT_TIMEOUT_EN
    assign timeout_err  = terr_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rect_loop_scheduler.sv
// Self-checking bench for rect_loop_scheduler: randomized sweeps against
// a nested-loop rectangle model with a flip-controller responder.
module tb_rect_loop_scheduler;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int IDX_W = 2;
    localparam int MB = 2;
    localparam int PER_MAT = (ROWS * (ROWS - 1) / 2) * (COLS * (COLS - 1) / 2);

    logic clk = 1'b0;
    logic rst, start, abort, fc_done;
    logic [7:0] base_addr, num_mats;
    logic fc_start, busy, done, aborted, timeout_err;
    logic [7:0] fc_base_addr;
    logic [IDX_W-1:0] fc_r1, fc_r2, fc_c1, fc_c2;
    logic [15:0] flip_count;

    int errors = 0;
    int checks = 0;

    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    int done_pulses, done_cyc, stable_err;
    bit timed_out, busy_after;
    logic [15:0] fc_at_done;
    logic ab_at_done, to_at_done;

    rect_loop_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W),
        .MAT_BYTES(MB), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .num_mats(num_mats),
        .fc_start(fc_start), .fc_base_addr(fc_base_addr),
        .fc_r1(fc_r1), .fc_r2(fc_r2), .fc_c1(fc_c1), .fc_c2(fc_c2),
        .fc_done(fc_done), .busy(busy), .done(done),
        .aborted(aborted), .timeout_err(timeout_err),
        .flip_count(flip_count)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [7:0] a, input int r1, input int r2,
                                       input int c1, input int c2);
        return {a, 8'(r1), 8'(r2), 8'(c1), 8'(c2)};
    endfunction

    function automatic logic [39:0] cur_obs();
        return {fc_base_addr, 8'(fc_r1), 8'(fc_r2), 8'(fc_c1), 8'(fc_c2)};
    endfunction

    // Reference: every r1<r2, c1<c2 pair per matrix, truncated at an abort.
    task automatic build_exp(input logic [7:0] b, input int n, input int abort_at);
        exp_q.delete();
        for (int m = 0; m < n; m++)
            for (int r1 = 0; r1 < ROWS; r1++)
                for (int r2 = r1 + 1; r2 < ROWS; r2++)
                    for (int c1 = 0; c1 < COLS; c1++)
                        for (int c2 = c1 + 1; c2 < COLS; c2++)
                            exp_q.push_back(mk(8'((int'(b) + m * MB) % 256), r1, r2, c1, c2));
        if (abort_at > 0)
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
    endtask

    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic run_sweep(input logic [7:0] b, input logic [7:0] n, input int lat_fix,
                             input int abort_at, input bit busy_start, input bit sa);
        int cnt;
        bit fin, pend;
        logic [39:0] cur;
        obs_q.delete();
        done_pulses = 0; done_cyc = -1; stable_err = 0;
        timed_out = 0; busy_after = 1; fin = 0; pend = 0; cnt = 0; cur = '0;
        base_addr = b; num_mats = n; start = 1; abort = sa;
        @(posedge clk); #1;
        start = 0; abort = 0;
        base_addr = 8'($urandom); num_mats = 8'($urandom);
        for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            fc_done = 0; abort = 0; start = 0;
            if (fc_start) begin
                cur = cur_obs();
                obs_q.push_back(cur);
                cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5));
                if (obs_q.size() == abort_at) pend = 1;
                if (busy_start && obs_q.size() == 2) begin
                    start = 1; base_addr = 8'($urandom); num_mats = 8'd0;
                end
            end else if (cnt > 0) begin
                if (cur_obs() !== cur) stable_err++;
                if (pend) begin abort = 1; pend = 0; end
                cnt--;
                if (cnt == 0) fc_done = 1;
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    fc_at_done = flip_count;
                    ab_at_done = aborted;
                    to_at_done = timeout_err;
                end
            end else if (done_cyc >= 0) begin
                busy_after = busy;
                fin = 1;
            end
        end
        if (!fin) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; abort = 0; fc_done = 0; base_addr = 0; num_mats = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        checks++;
        if ({busy, done, fc_start, aborted, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fc_start, aborted, timeout_err});
        end
        checks++;
        if ({flip_count, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2} !== '0) begin
            errors++;
            $display("FAIL reset_data: cnt=%0d addr=%h r=%0d,%0d c=%0d,%0d want all 0",
                     flip_count, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2);
        end
    endtask

    task automatic test_single_matrix();
        int d;
        run_sweep(8'h10, 8'd1, 3, 0, 0, 0);
        build_exp(8'h10, 1, 0);
        d = first_diff();
        checks++;
        if (timed_out) begin errors++; $display("FAIL single_timeout: no done within budget"); end
        checks++;
        if (obs_q.size() != 36) begin errors++; $display("FAIL single_count: got %0d want 36", obs_q.size()); end
        checks++;
        if (d != -1) begin errors++; $display("FAIL single_seq: first diff %0d", d); end
        checks++;
        if (obs_q.size() > 0 && obs_q[0] !== mk(8'h10, 0, 1, 0, 1)) begin
            errors++; $display("FAIL single_first: got %h want %h", obs_q[0], mk(8'h10, 0, 1, 0, 1));
        end
        checks++;
        if (obs_q.size() > 0 && obs_q[obs_q.size()-1] !== mk(8'h10, 2, 3, 2, 3)) begin
            errors++; $display("FAIL single_last: got %h want %h", obs_q[obs_q.size()-1], mk(8'h10, 2, 3, 2, 3));
        end
        checks++;
        if (fc_at_done !== 16'd36) begin errors++; $display("FAIL single_flips: got %0d want 36", fc_at_done); end
        checks++;
        if (done_pulses != 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", done_pulses); end
        checks++;
        if (stable_err != 0) begin errors++; $display("FAIL single_stable: got %0d changes want 0", stable_err); end
        checks++;
        if ({ab_at_done, to_at_done, busy_after} !== 3'b000) begin
            errors++; $display("FAIL single_status: got %b want 000", {ab_at_done, to_at_done, busy_after});
        end
    endtask

    task automatic test_two_matrices();
        int d;
        run_sweep(8'h10, 8'd2, 0, 0, 0, 0);
        build_exp(8'h10, 2, 0);
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL two_seq: first diff %0d size %0d", d, obs_q.size()); end
        checks++;
        if (obs_q.size() == 72 && (obs_q[36][39:32] !== 8'h12 || obs_q[71][39:32] !== 8'h12)) begin
            errors++; $display("FAIL two_addr: got %h want 12", obs_q[36][39:32]);
        end
        checks++;
        if (fc_at_done !== 16'd72) begin errors++; $display("FAIL two_flips: got %0d want 72", fc_at_done); end
    endtask

    task automatic test_zero_mats();
        run_sweep(8'h55, 8'd0, 1, 0, 0, 0);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL zero_starts: got %0d want 0", obs_q.size()); end
        checks++;
        if (done_cyc < 1 || done_cyc > 2) begin
            errors++; $display("FAIL zero_latency: got %0d want 1..2", done_cyc);
        end
        checks++;
        if (fc_at_done !== 16'd0 || done_pulses != 1) begin
            errors++; $display("FAIL zero_flips: got %0d/%0d want 0/1", fc_at_done, done_pulses);
        end
    endtask

    task automatic test_abort();
        run_sweep(8'h10, 8'd1, 2, 5, 0, 0);
        checks++;
        if (obs_q.size() != 5) begin errors++; $display("FAIL abort_starts: got %0d want 5", obs_q.size()); end
        checks++;
        if (fc_at_done !== 16'd5 || ab_at_done !== 1'b1) begin
            errors++; $display("FAIL abort_status: got cnt=%0d ab=%b want 5/1", fc_at_done, ab_at_done);
        end
    endtask

    task automatic test_addr_wrap();
        int d;
        run_sweep(8'hFF, 8'd2, 1, 0, 0, 0);
        build_exp(8'hFF, 2, 0);
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL wrap_seq: first diff %0d", d); end
        checks++;
        if (obs_q.size() > 36 && obs_q[36][39:32] !== 8'h01) begin
            errors++; $display("FAIL wrap_addr: got %h want 01", obs_q[36][39:32]);
        end
    endtask

    task automatic test_start_abort_idle();
        run_sweep(8'h20, 8'd1, 1, 0, 0, 1);
        checks++;
        if (obs_q.size() != 36 || ab_at_done !== 1'b0) begin
            errors++; $display("FAIL start_abort: got %0d flips ab=%b want 36/0", obs_q.size(), ab_at_done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            logic [7:0] b;
            int n, ab, d, exp_n;
            bit bs;
            b = 8'($urandom);
            n = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * PER_MAT)) : 0;
            bs = 1'($urandom_range(0, 1));
            run_sweep(b, 8'(n), 0, ab, bs, 0);
            build_exp(b, n, ab);
            exp_n = (ab > 0) ? ab : n * PER_MAT;
            d = first_diff();
            checks++;
            if (timed_out || d != -1) begin
                errors++; $display("FAIL rand_seq[%0d]: diff %0d size %0d want %0d", it, d, obs_q.size(), exp_n);
            end
            checks++;
            if (fc_at_done !== 16'(exp_n) || ab_at_done !== (ab > 0) || done_pulses != 1) begin
                errors++;
                $display("FAIL rand_status[%0d]: cnt=%0d ab=%b pulses=%0d want %0d/%b/1",
                         it, fc_at_done, ab_at_done, done_pulses, exp_n, ab > 0);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit got;
        got = 0;
        base_addr = 8'h40; num_mats = 8'd1; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 20; i++) begin
            if (fc_start) begin got = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rstwait_issue: got no fc_start want one"); end
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if ({busy, done, fc_start, aborted, timeout_err, flip_count, fc_base_addr,
             fc_r1, fc_r2, fc_c1, fc_c2} !== '0) begin
            errors++;
            $display("FAIL rstwait_vals: busy=%b addr=%h cnt=%0d want all 0", busy, fc_base_addr, flip_count);
        end
    endtask

`ifdef RECT_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        bit got;
        got = 0; k = 0;
        base_addr = 8'h10; num_mats = 8'd1; start = 1; fc_done = 0;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 20 && !fc_start; i++) begin @(posedge clk); #1; end
        for (int i = 1; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin k = i; got = 1; break; end
        end
        checks++;
        if (!got || k != 256) begin errors++; $display("FAIL timeout_lat: got %0d want 256", k); end
        checks++;
        if (timeout_err !== 1'b1 || flip_count !== 16'd0) begin
            errors++; $display("FAIL timeout_status: err=%b cnt=%0d want 1/0", timeout_err, flip_count);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_matrix();
        test_two_matrices();
        test_zero_mats();
        test_abort();
        test_addr_wrap();
        test_start_abort_idle();
        test_random();
`ifdef RECT_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
